decode_stage: RTL and testbench

//  Registered instruction-decode stage for the pipelined MIPS core. Sits between fetch and execute.

---
 rtl/mips_pkg.sv | 153 +++++++++++++++
 rtl/mul_interlock.sv | 49 ++++
 rtl/decode_stage.sv | 115 +++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Opcode/funct constants, ALU and branch encodings, the decode
//                control bundle and the combinational decoder for the MIPS
//                decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [2:0] {
    ALU_SLTU  = 3'b000,
    ALU_SUBU  = 3'b001,
    ALU_MFHI  = 3'b010,
    ALU_MFLO  = 3'b011,
    ALU_MULTU = 3'b100,
    ALU_ADDU  = 3'b101,
    ALU_OR    = 3'b110,
    ALU_AND   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BLTZ = 2'b10
  } branch_e;

  typedef struct packed {
    logic        memtoreg;
    logic        memwrite;
    logic        alusrcbimm;
    logic        regwrite;
    logic        dojump;
    logic        link;
    logic        jumpreg;
    logic        usevalue;
    branch_e     branchcond;
    logic [4:0]  destreg;
    alu_op_e     alucontrol;
    logic [31:0] value;
    logic        illegal;
  } ctrl_bundle_t;

  // MFHI/MFLO read HI/LO and must wait out a MULTU in flight.
  function automatic logic reads_hilo(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) &&
           ((instr[5:0] == FN_MFHI) || (instr[5:0] == FN_MFLO));
  endfunction

  // Every field starts at zero so unused controls, and the whole bundle of
  // an undefined instruction apart from the illegal flag, register as 0.
  function automatic ctrl_bundle_t decode_fn(input logic [31:0] instr);
    ctrl_bundle_t b;
    b = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_SLTU:  b.alucontrol = ALU_SLTU;
          FN_SUBU:  b.alucontrol = ALU_SUBU;
          FN_MFHI:  b.alucontrol = ALU_MFHI;
          FN_MFLO:  b.alucontrol = ALU_MFLO;
          FN_MULTU: b.alucontrol = ALU_MULTU;
          FN_ADDU:  b.alucontrol = ALU_ADDU;
          FN_OR:    b.alucontrol = ALU_OR;
          FN_AND:   b.alucontrol = ALU_AND;
          FN_JR: begin
            b.dojump  = 1'b1;
            b.jumpreg = 1'b1;
          end
          default:  b.illegal = 1'b1;
        endcase
        // All defined R-type ops other than JR write rd.
        if (!b.illegal && !b.dojump) begin
          b.regwrite = 1'b1;
          b.destreg  = instr[15:11];
        end
      end
      OP_LW: begin
        b.regwrite   = 1'b1;
        b.memtoreg   = 1'b1;
        b.alusrcbimm = 1'b1;
        b.alucontrol = ALU_ADDU;
        b.destreg    = instr[20:16];
      end
      OP_SW: begin
        b.memwrite   = 1'b1;
        b.memtoreg   = 1'b1;
        b.alusrcbimm = 1'b1;
        b.alucontrol = ALU_ADDU;
      end
      OP_BEQ: begin
        b.branchcond = BR_BEQ;
        b.alucontrol = ALU_SUBU;
      end
      OP_BLTZ: begin
        b.branchcond = BR_BLTZ;
        b.alucontrol = ALU_SLTU;
      end
      OP_ADDIU: begin
        b.regwrite   = 1'b1;
        b.destreg    = instr[20:16];
        b.alusrcbimm = 1'b1;
        b.alucontrol = ALU_ADDU;
      end
      OP_J: b.dojump = 1'b1;
      OP_JAL: begin
        b.dojump   = 1'b1;
        b.link     = 1'b1;
        b.regwrite = 1'b1;
        b.destreg  = 5'd31;
      end
      OP_LUI: begin
        b.regwrite = 1'b1;
        b.destreg  = instr[20:16];
        b.usevalue = 1'b1;
        b.value    = {instr[15:0], 16'h0000};
      end
      OP_ORI: begin
        b.regwrite   = 1'b1;
        b.destreg    = instr[20:16];
        b.alusrcbimm = 1'b1;
        b.alucontrol = ALU_OR;
      end
      default: b.illegal = 1'b1;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_interlock.sv
`default_nettype none
// ============================================================================
//  Module      : mul_interlock
//  Description : Counts the cycles HI/LO stay unavailable after a MULTU
//                leaves the decode stage.
//  Ports       : clk      in  clock, rising edge
//                reset    in  asynchronous active-high reset
//                load     in  MULTU transferring to execute this cycle
//                mul_busy out counter nonzero
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_interlock #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic mul_busy
);

  localparam int            CNT_W  = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A fresh MULTU restarts the full window even if one is still counting.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = C_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mul_busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered MIPS decode stage between fetch and execute with
//                valid/ready handshakes, flush and a MULTU -> MFHI/MFLO
//                interlock.
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready/instr   fetch side handshake
//                flush                     kill held instruction
//                out_valid/out_ready       execute side handshake
//                memtoreg..usevalue, branchcond, destreg, alucontrol, value,
//                illegal                   registered control bundle
//                mul_busy                  MULTU latency counter nonzero
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_LAT   = 4,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 memtoreg,
  output logic                 memwrite,
  output logic                 alusrcbimm,
  output logic                 regwrite,
  output logic                 dojump,
  output logic                 link,
  output logic                 jumpreg,
  output logic                 usevalue,
  output logic [1:0]           branchcond,
  output logic [4:0]           destreg,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [DATA_W-1:0]    value,
  output logic                 illegal,
  output logic                 mul_busy
);

  logic         out_valid_q;
  logic         out_valid_d;
  ctrl_bundle_t bundle_q;
  ctrl_bundle_t bundle_d;

  logic w_held_is_multu;
  logic w_hazard;
  logic w_accept;
  logic w_mul_load;

  // Only a MULTU decodes to the multu ALU op, so the held bundle identifies it.
  assign w_held_is_multu = out_valid_q && (bundle_q.alucontrol == ALU_MULTU);
  assign w_hazard        = mul_busy || w_held_is_multu;
  assign in_ready        = !flush && (!out_valid_q || out_ready) &&
                           !(w_hazard && reads_hilo(instr));
  assign w_accept        = in_valid && in_ready;
  assign w_mul_load      = w_held_is_multu && out_ready && !flush;

  mul_interlock #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_interlock (
    .clk      (clk),
    .reset    (reset),
    .load     (w_mul_load),
    .mul_busy (mul_busy)
  );

  // Bundle only changes on accept, so drained and flushed slots keep their
  // last contents stable.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
      bundle_d    = decode_fn(instr);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign memtoreg   = bundle_q.memtoreg;
  assign memwrite   = bundle_q.memwrite;
  assign alusrcbimm = bundle_q.alusrcbimm;
  assign regwrite   = bundle_q.regwrite;
  assign dojump     = bundle_q.dojump;
  assign link       = bundle_q.link;
  assign jumpreg    = bundle_q.jumpreg;
  assign usevalue   = bundle_q.usevalue;
  assign branchcond = bundle_q.branchcond;
  assign destreg    = bundle_q.destreg;
  assign alucontrol = ALUCTRL_W'(bundle_q.alucontrol);
  assign value      = DATA_W'(bundle_q.value);
  assign illegal    = bundle_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                followed by random traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int DATA_W    = 32;
  localparam int MUL_LAT   = 4;
  localparam int ALUCTRL_W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        memtoreg, memwrite, alusrcbimm, regwrite, dojump, link, jumpreg, usevalue;
  logic [1:0]  branchcond;
  logic [4:0]  destreg;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic [DATA_W-1:0]    value;
  logic        illegal;
  logic        mul_busy;

  decode_stage #(
    .DATA_W    (DATA_W),
    .MUL_LAT   (MUL_LAT),
    .ALUCTRL_W (ALUCTRL_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .memtoreg   (memtoreg),
    .memwrite   (memwrite),
    .alusrcbimm (alusrcbimm),
    .regwrite   (regwrite),
    .dojump     (dojump),
    .link       (link),
    .jumpreg    (jumpreg),
    .usevalue   (usevalue),
    .branchcond (branchcond),
    .destreg    (destreg),
    .alucontrol (alucontrol),
    .value      (value),
    .illegal    (illegal),
    .mul_busy   (mul_busy)
  );

  always #5 clk = ~clk;

  logic [50:0] dut_out;
  assign dut_out = {memtoreg, memwrite, alusrcbimm, regwrite, dojump, link, jumpreg,
                    usevalue, branchcond, destreg, alucontrol, value, illegal};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid;
  bit          m_have;
  logic [31:0] m_instr;
  int          m_mul;
  bit          last_rdy;

  function automatic bit is_multu(input logic [31:0] w);
    return (w[31:26] == 6'h00) && (w[5:0] == 6'h19);
  endfunction

  function automatic bit is_mf(input logic [31:0] w);
    return (w[31:26] == 6'h00) && ((w[5:0] == 6'h10) || (w[5:0] == 6'h12));
  endfunction

  // Expected outputs straight from the instruction table, packed in port order.
  function automatic logic [50:0] ref_decode(input logic [31:0] w);
    bit mtr, mw, asi, rw, dj, lk, jr, uv, ill;
    logic [1:0]  bc;
    logic [4:0]  dr;
    logic [2:0]  alu;
    logic [31:0] val;
    {mtr, mw, asi, rw, dj, lk, jr, uv, ill} = '0;
    bc = 2'd0; dr = 5'd0; alu = 3'd0; val = 32'd0;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h2b: alu = 3'd0;
          6'h23: alu = 3'd1;
          6'h10: alu = 3'd2;
          6'h12: alu = 3'd3;
          6'h19: alu = 3'd4;
          6'h21: alu = 3'd5;
          6'h25: alu = 3'd6;
          6'h24: alu = 3'd7;
          6'h08: begin dj = 1; jr = 1; end
          default: ill = 1;
        endcase
        if (!ill && !jr) begin rw = 1; dr = w[15:11]; end
      end
      6'h23: begin rw = 1; mtr = 1; asi = 1; alu = 3'd5; dr = w[20:16]; end
      6'h2b: begin mw = 1; mtr = 1; asi = 1; alu = 3'd5; end
      6'h04: begin bc = 2'b01; alu = 3'd1; end
      6'h01: begin bc = 2'b10; alu = 3'd0; end
      6'h09: begin rw = 1; dr = w[20:16]; asi = 1; alu = 3'd5; end
      6'h02: dj = 1;
      6'h03: begin dj = 1; lk = 1; rw = 1; dr = 5'd31; end
      6'h0f: begin rw = 1; dr = w[20:16]; uv = 1; val = w[15:0] * 32'h10000; end
      6'h0d: begin rw = 1; dr = w[20:16]; asi = 1; alu = 3'd6; end
      default: ill = 1;
    endcase
    return {mtr, mw, asi, rw, dj, lk, jr, uv, bc, dr, alu, val, ill};
  endfunction

  function automatic bit model_ready(input logic [31:0] ins, input bit fl, input bit ordy);
    bit hazard;
    hazard = (m_mul > 0) || (m_valid && is_multu(m_instr));
    return !fl && (!m_valid || ordy) && !(hazard && is_mf(ins));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_have = 0; m_instr = '0; m_mul = 0;
  endtask

  // Entered one time unit after a rising edge; returns at the same point
  // of the following cycle.
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit fl, input bit ordy);
    bit acc;
    bit ld;
    in_valid  = iv;
    instr     = ins;
    flush     = fl;
    out_ready = ordy;
    #1;
    last_rdy = in_ready;
    check("in_ready",  in_ready,  model_ready(ins, fl, ordy));
    check("out_valid", out_valid, m_valid);
    check("mul_busy",  mul_busy,  m_mul > 0);
    check("bundle",    dut_out,   m_have ? ref_decode(m_instr) : 51'd0);
    acc = iv && model_ready(ins, fl, ordy);
    ld  = m_valid && ordy && !fl && is_multu(m_instr);
    @(posedge clk);
    if (ld)             m_mul = MUL_LAT;
    else if (m_mul > 0) m_mul = m_mul - 1;
    if (fl)                     m_valid = 0;
    else if (acc) begin         m_valid = 1; m_have = 1; m_instr = ins; end
    else if (m_valid && ordy)   m_valid = 0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fns [10];
    logic [5:0]  ops [9];
    int sel;
    fns = '{6'h2b, 6'h23, 6'h10, 6'h12, 6'h19, 6'h21, 6'h25, 6'h24, 6'h08, 6'h3f};
    ops = '{6'h23, 6'h2b, 6'h04, 6'h01, 6'h09, 6'h02, 6'h03, 6'h0f, 6'h0d};
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 2) begin
      // fully random word, mostly undefined opcodes
    end else if (sel < 5) begin
      w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 9)];
    end else if (sel < 7) begin
      w[31:26] = 6'h00; w[5:0] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12;
    end else if (sel < 8) begin
      w[31:26] = 6'h00; w[5:0] = 6'h19;
    end else begin
      w[31:26] = ops[$urandom_range(0, 8)];
    end
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [50:0] snap;
    int stalls;
    reset = 1; in_valid = 0; instr = '0; flush = 0; out_ready = 0;
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_busy",  mul_busy,  0);
    check("rst_bundle",    dut_out,   0);
    reset = 0;
    @(posedge clk); #1;

    // ADDIU $8, $0, 5
    cycle(1, 32'h24080005, 0, 1);
    check("addiu_valid",   out_valid,  1);
    check("addiu_destreg", destreg,    8);
    check("addiu_alu",     alucontrol, 3'b101);
    check("addiu_imm",     alusrcbimm, 1);
    check("addiu_rw",      regwrite,   1);

    // LUI $9, 0x1234
    cycle(1, 32'h3C091234, 0, 1);
    check("lui_value",   value,    32'h12340000);
    check("lui_usevalue", usevalue, 1);
    check("lui_destreg", destreg,  9);

    // MULTU then MFLO: stalled while MULTU is held, then for MUL_LAT cycles
    cycle(1, 32'h01090019, 0, 1);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 32'h00005012, 0, 1);
      if (last_rdy) break;
      stalls++;
    end
    check("mflo_stalls", stalls, MUL_LAT + 1);
    check("mflo_alu",    alucontrol, 3'b011);

    // undefined opcode
    cycle(1, 32'hFC000000, 0, 1);
    check("ill_flag",  illegal,   1);
    check("ill_rw",    regwrite,  0);
    check("ill_mw",    memwrite,  0);
    check("ill_jump",  dojump,    0);
    check("ill_valid", out_valid, 1);

    // backpressure then flush
    snap = dut_out;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h24080005, 0, 0);
      check("hold_stable", dut_out,   snap);
      check("hold_valid",  out_valid, 1);
    end
    cycle(1, 32'h24080005, 1, 0);
    check("flush_valid", out_valid, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
    end
    cycle(0, 32'h0, 0, 1);
    cycle(0, 32'h0, 0, 1);

    // asynchronous reset in the middle of an interlock window
    cycle(1, 32'h01090019, 0, 1);
    cycle(1, 32'h24080005, 0, 1);
    check("pre_rst_busy",  mul_busy,  1);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy",  mul_busy,  0);
    check("async_rst_bundle", dut_out,  0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    cycle(0, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
